// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: halts the core, walks x0..x(NREGS-1) through the
// register file read port and streams {index, value} beats out on a
// valid/ready port, then releases the core. Abort (explicit, or halt_ack
// falling while the core should be stalled) jumps straight to release.
module regfile_dump_ctrl #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            halt_req,
  input  logic            halt_ack,
  output logic            rf_ren,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_idx,
  output logic [XLEN-1:0] out_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HALT_WAIT = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_CAPTURE   = 3'd3;
  localparam logic [2:0] S_EMIT      = 3'd4;
  localparam logic [2:0] S_RELEASE   = 3'd5;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [2:0]      r_state;
  logic [2:0]      w_nstate;
  logic            w_kill;
  logic            w_accept;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   r_out_idx;
  logic [XLEN-1:0] r_out_data;
  logic            r_done;
  logic            r_aborted;

  // Next-state decode; w_kill covers explicit abort and a lost halt_ack,
  // and overrides any forward progress in the same cycle.
  always_comb begin
    w_nstate = r_state;
    w_kill   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE:      if (start) w_nstate = S_HALT_WAIT;
      S_HALT_WAIT: begin
        if (abort)         w_kill   = 1'b1;
        else if (halt_ack) w_nstate = S_READ;
      end
      S_READ: begin
        if (abort || !halt_ack) w_kill   = 1'b1;
        else                    w_nstate = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort || !halt_ack) w_kill   = 1'b1;
        else                    w_nstate = S_EMIT;
      end
      S_EMIT: begin
        if (abort || !halt_ack) w_kill = 1'b1;
        else if (out_ready) begin
          w_accept = 1'b1;
          w_nstate = (r_idx == LAST_IDX) ? S_RELEASE : S_READ;
        end
      end
      S_RELEASE:   if (!halt_ack) w_nstate = S_IDLE;
      default:     w_nstate = S_IDLE;
    endcase
    if (w_kill) w_nstate = S_RELEASE;
  end

  // State, index and beat registers; reset returns to IDLE with everything low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_out_idx  <= '0;
      r_out_data <= '0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_done  <= (r_state == S_RELEASE) && !halt_ack;
      if (r_state == S_IDLE && start) begin
        r_idx     <= '0;
        r_aborted <= 1'b0;
      end else if (w_kill) begin
        r_aborted <= 1'b1;
      end
      // idx saturates at the last register; RELEASE follows that beat
      if (w_accept && r_idx != LAST_IDX) r_idx <= r_idx + AW'(1);
      // read data arrives the cycle after READ, i.e. during CAPTURE
      if (r_state == S_CAPTURE && !w_kill) begin
        r_out_data <= rf_rdata;
        r_out_idx  <= r_idx;
      end
    end
  end

  // Outputs decoded from state or taken straight from registers.
  assign busy      = (r_state != S_IDLE);
  assign halt_req  = (r_state == S_HALT_WAIT) || (r_state == S_READ) ||
                     (r_state == S_CAPTURE)   || (r_state == S_EMIT);
  assign rf_ren    = (r_state == S_READ);
  assign rf_raddr  = (r_state == S_READ) ? r_idx : '0;
  assign out_valid = (r_state == S_EMIT);
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign done      = r_done;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: a small core/regfile model answers
// halt_req and rf_ren; each scenario task checks its own results inline.
module tb_regfile_dump_ctrl;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0, abort = 1'b0, halt_ack = 1'b0, out_ready = 1'b0;
  logic            busy, done, aborted, halt_req, rf_ren, out_valid;
  logic [AW-1:0]   rf_raddr, out_idx;
  logic [XLEN-1:0] rf_rdata = '0, out_data;
  logic [47:0]     all_outs;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_dump_ctrl #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
    .done(done), .aborted(aborted), .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  assign all_outs = {busy, done, aborted, halt_req, rf_ren, rf_raddr,
                     out_valid, out_idx, out_data};

  // register file contents: x0 = 0, xi = 0x100 + i
  function automatic logic [XLEN-1:0] rv(input int i);
    return (i == 0) ? '0 : XLEN'(32'h100 + i);
  endfunction

  // regfile read port, one cycle latency
  always @(posedge clk) rf_rdata <= rf_ren ? rv(int'(rf_raddr)) : '0;

  // results recorded by run_dump
  int              nbeats, stab_err, done_cnt;
  logic [AW-1:0]   b_idx [64];
  logic [XLEN-1:0] b_dat [64];
  bit              saw_done, evt_seen;
  logic            done_aborted, evt_hreq, evt_valid, last_hreq_after;
  logic            busy_after_start, aborted_after_start, hreq_after_start;

  // Drives one dump: core acks 2 cycles after halt_req; optional abort at
  // an EMIT index, halt_ack drop at a READ index, abort with the start pulse,
  // and an extra start while busy at cycle restart_cyc.
  task automatic run_dump(input int rmode, input int abort_idx, input int drop_idx,
                          input bit start_abort, input int restart_cyc);
    int ackcnt = 0;
    bit pstall = 0, dropped = 0, evt_pend = 0, last_pend = 0;
    logic [AW-1:0]   pidx = '0;
    logic [XLEN-1:0] pdat = '0;
    nbeats = 0; stab_err = 0; done_cnt = 0; saw_done = 0; evt_seen = 0;
    done_aborted = 1'bx; evt_hreq = 1'bx; evt_valid = 1'bx; last_hreq_after = 1'bx;
    @(negedge clk); start = 1'b1; abort = start_abort; out_ready = 1'b0;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    busy_after_start = busy; aborted_after_start = aborted; hreq_after_start = halt_req;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (evt_pend)  begin evt_hreq = halt_req; evt_valid = out_valid; evt_seen = 1; evt_pend = 0; end
      if (last_pend) begin last_hreq_after = halt_req; last_pend = 0; end
      if (pstall && (out_valid !== 1'b1 || out_idx !== pidx || out_data !== pdat)) stab_err++;
      if (saw_done) begin
        if (done === 1'b1) done_cnt++;
        break;
      end
      if (done === 1'b1) begin saw_done = 1; done_cnt++; done_aborted = aborted; end
      start     = (cyc == restart_cyc);
      abort     = 1'b0;
      out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (halt_req === 1'b1) begin ackcnt++; halt_ack = (ackcnt >= 2) && !dropped; end
      else begin ackcnt = 0; halt_ack = 1'b0; end
      if (rf_ren === 1'b1 && int'(rf_raddr) == drop_idx && !dropped) begin
        dropped = 1; halt_ack = 1'b0; evt_pend = 1;
      end
      if (out_valid === 1'b1 && int'(out_idx) == abort_idx) begin
        abort = 1'b1; out_ready = 1'b1; evt_pend = 1;
      end
      pstall = (out_valid === 1'b1) && !out_ready && !abort;
      if (out_valid === 1'b1 && out_ready && !abort) begin
        if (nbeats < 64) begin b_idx[nbeats] = out_idx; b_dat[nbeats] = out_data; end
        nbeats++;
        if (int'(out_idx) == NREGS - 1) last_pend = 1;
      end
      pidx = out_idx; pdat = out_data;
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0; halt_ack = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (all_outs !== 48'h0) $display("FAIL reset_in: outputs=%h want 0", all_outs);
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (all_outs !== 48'h0) $display("FAIL reset_after: outputs=%h want 0", all_outs);
    else n_pass++;
  endtask

  task automatic test_full_dump;
    run_dump(0, -1, -1, 1'b0, -1);
    n_checks++;
    if (hreq_after_start !== 1'b1) $display("FAIL full_hreq_latency: halt_req=%b want 1", hreq_after_start);
    else n_pass++;
    n_checks++;
    if (nbeats !== 32) $display("FAIL full_nbeats: got %0d want 32", nbeats);
    else n_pass++;
    for (int i = 0; i < 32 && i < nbeats; i++) begin
      n_checks++;
      if (b_idx[i] !== AW'(i) || b_dat[i] !== rv(i))
        $display("FAIL full_beat%0d: idx=%0d data=%h want idx=%0d data=%h", i, b_idx[i], b_dat[i], i, rv(i));
      else n_pass++;
    end
    n_checks++;
    if (last_hreq_after !== 1'b0) $display("FAIL full_hreq_drop: halt_req=%b want 0", last_hreq_after);
    else n_pass++;
    n_checks++;
    if (!saw_done || done_cnt !== 1 || done_aborted !== 1'b0)
      $display("FAIL full_done: seen=%0d pulses=%0d aborted=%b want 1/1/0", saw_done, done_cnt, done_aborted);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL full_busy_end: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int bad = 0;
    run_dump(1, -1, -1, 1'b0, -1);
    n_checks++;
    if (stab_err !== 0) $display("FAIL bp_stable: violations=%0d want 0", stab_err);
    else n_pass++;
    n_checks++;
    if (nbeats !== 32) $display("FAIL bp_nbeats: got %0d want 32", nbeats);
    else n_pass++;
    for (int i = 0; i < 32 && i < nbeats; i++)
      if (b_idx[i] !== AW'(i) || b_dat[i] !== rv(i)) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL bp_sequence: bad beats=%0d want 0", bad);
    else n_pass++;
    n_checks++;
    if (!saw_done || done_aborted !== 1'b0) $display("FAIL bp_done: seen=%0d aborted=%b want 1/0", saw_done, done_aborted);
    else n_pass++;
  endtask

  task automatic test_abort_emit;
    run_dump(0, 7, -1, 1'b0, -1);
    n_checks++;
    if (nbeats !== 7) $display("FAIL abort_nbeats: got %0d want 7", nbeats);
    else n_pass++;
    n_checks++;
    if (!evt_seen || evt_hreq !== 1'b0 || evt_valid !== 1'b0)
      $display("FAIL abort_release: halt_req=%b out_valid=%b want 0/0", evt_hreq, evt_valid);
    else n_pass++;
    n_checks++;
    if (!saw_done || done_cnt !== 1 || done_aborted !== 1'b1)
      $display("FAIL abort_done: seen=%0d pulses=%0d aborted=%b want 1/1/1", saw_done, done_cnt, done_aborted);
    else n_pass++;
  endtask

  task automatic test_start_abort_restart;
    int bad = 0;
    run_dump(0, -1, -1, 1'b1, 5);
    n_checks++;
    if (busy_after_start !== 1'b1 || hreq_after_start !== 1'b1 || aborted_after_start !== 1'b0)
      $display("FAIL sa_start: busy=%b halt_req=%b aborted=%b want 1/1/0",
               busy_after_start, hreq_after_start, aborted_after_start);
    else n_pass++;
    n_checks++;
    if (nbeats !== 32) $display("FAIL sa_nbeats: got %0d want 32", nbeats);
    else n_pass++;
    for (int i = 0; i < 32 && i < nbeats; i++)
      if (b_idx[i] !== AW'(i) || b_dat[i] !== rv(i)) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL sa_sequence: bad beats=%0d want 0", bad);
    else n_pass++;
    n_checks++;
    if (!saw_done || done_aborted !== 1'b0) $display("FAIL sa_done: seen=%0d aborted=%b want 1/0", saw_done, done_aborted);
    else n_pass++;
  endtask

  task automatic test_halt_drop;
    run_dump(0, -1, 3, 1'b0, -1);
    n_checks++;
    if (nbeats !== 3) $display("FAIL drop_nbeats: got %0d want 3", nbeats);
    else n_pass++;
    n_checks++;
    if (!evt_seen || evt_hreq !== 1'b0) $display("FAIL drop_hreq: halt_req=%b want 0", evt_hreq);
    else n_pass++;
    n_checks++;
    if (!saw_done || done_aborted !== 1'b1) $display("FAIL drop_done: seen=%0d aborted=%b want 1/1", saw_done, done_aborted);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int  dpulse = 0;
    bit  got_valid = 0;
    @(negedge clk); start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 50 && !got_valid; c++) begin
      halt_ack = halt_req;
      if (out_valid === 1'b1) got_valid = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!got_valid) $display("FAIL rstmid_reach_emit: out_valid never rose within 50 cycles");
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== 48'h0) $display("FAIL rstmid_async: outputs=%h want 0", all_outs);
    else n_pass++;
    @(negedge clk); halt_ack = 1'b0; rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done === 1'b1) dpulse++;
    end
    n_checks++;
    if (dpulse !== 0) $display("FAIL rstmid_no_done: done pulses=%0d want 0", dpulse);
    else n_pass++;
    run_dump(0, -1, -1, 1'b0, -1);
    n_checks++;
    if (nbeats !== 32 || !saw_done || done_aborted !== 1'b0)
      $display("FAIL rstmid_fresh: beats=%0d done=%0d aborted=%b want 32/1/0", nbeats, saw_done, done_aborted);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_abort_emit();
    test_start_abort_restart();
    test_halt_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
